// File: rtl/dds_mixer_pkg.sv
// dds_mixer_pkg: shared modem types, sine-table init and rounding reference
//   DEF_*       default widths for the mixer datapath
//   t_iq        signed I/Q sample type
//   sin_entry   round-half-up(amp * sin(2*pi*k / 2^phase_w))
//   div_round   x / 2^sh, rounded half away from zero
package dds_mixer_pkg;

    localparam int  DEF_DATA_W  = 16;
    localparam int  DEF_PHASE_W = 12;
    localparam int  DEF_ACC_W   = 32;
    localparam real PI          = 3.14159265358979323846;

    typedef logic signed [DEF_DATA_W-1:0] t_iq;

    function automatic int sin_entry(input int k, input int phase_w, input int amp);
        return $rtoi($floor(real'(amp) * $sin(2.0 * PI * real'(k) / real'(1 << phase_w)) + 0.5));
    endfunction

    function automatic longint div_round(input longint x, input int sh);
        longint h;
        h = longint'(1) << (sh - 1);
        return (x < 0) ? -((h - x) >>> sh) : ((x + h) >>> sh);
    endfunction

endpackage

// File: rtl/dds_mixer_sincos_lut.sv
// dds_mixer_sincos_lut: registered full-wave sin/cos ROM, one cycle latency
//   iclk  clock
//   iidx  phase index, 2^PHASE_W entries per turn
//   osin  sin at iidx
//   ocos  cos at iidx (sin read a quarter turn ahead)
module dds_mixer_sincos_lut
    import dds_mixer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int AMP     = 2**(DATA_W-1)-1
) (
    input  logic                      iclk,
    input  logic [PHASE_W-1:0]        iidx,
    output logic signed [DATA_W-1:0]  osin,
    output logic signed [DATA_W-1:0]  ocos
);

    localparam int                 N   = 1 << PHASE_W;
    localparam logic [PHASE_W-1:0] QTR = PHASE_W'(N / 4);

    logic signed [DATA_W-1:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        assign rom[k] = DATA_W'(sin_entry(k, PHASE_W, AMP));
    end

    // the quarter-turn offset wraps naturally in PHASE_W bits
    always_ff @(posedge iclk) begin
        osin <= rom[iidx];
        ocos <= rom[iidx + QTR];
    end

endmodule

// File: rtl/dds_mixer.sv
// dds_mixer: NCO-driven complex frequency shifter, 5-cycle fixed latency
//   iclk, ireset            clock, synchronous active-high reset
//   iphase_inc(_vld)        phase increment and its load strobe
//   iphase_clr              zero the phase accumulator
//   ivalid, ii, iq          input sample
//   ovalid, oi, oq          shifted output sample (held while ovalid is low)
//   ophase                  LUT index used for the output sample
module dds_mixer
    import dds_mixer_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int AMP     = 2**(DATA_W-1)-1,
    parameter bit CONJ    = 1'b0
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic [ACC_W-1:0]          iphase_inc,
    input  logic                      iphase_inc_vld,
    input  logic                      iphase_clr,
    input  logic                      ivalid,
    input  logic signed [DATA_W-1:0]  ii,
    input  logic signed [DATA_W-1:0]  iq,
    output logic                      ovalid,
    output logic signed [DATA_W-1:0]  oi,
    output logic signed [DATA_W-1:0]  oq,
    output logic [PHASE_W-1:0]        ophase
);

    localparam int PW   = 2 * DATA_W;
    localparam int SW   = PW + 1;
    localparam int HALF = 1 << (DATA_W - 2);
    localparam int MAXV = 2**(DATA_W-1) - 1;

    logic [ACC_W-1:0]          acc_q, acc_d, acc_base, inc_q;
    logic [3:0]                vld_q;
    logic signed [DATA_W-1:0]  i0_q, q0_q, i1_q, q1_q, lut_sin, lut_cos;
    logic [PHASE_W-1:0]        idx_d, idx0_q, idx1_q, idx2_q, idx3_q;
    logic signed [PW-1:0]      pic_q, pqs_q, pqc_q, pis_q;
    logic signed [SW-1:0]      si_q, sq_q, si_d, sq_d;

    // |s| + half LSB, shift, clip magnitude, then restore sign: rounds half away
    // from zero and keeps the clip symmetric so the most negative code never appears
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SW-1:0] s);
        logic [SW-1:0] mag, q, sat;
        mag = (s[SW-1] ? -s : s) + SW'(HALF);
        q   = mag >> (DATA_W - 1);
        sat = (q > SW'(MAXV)) ? SW'(MAXV) : q;
        return s[SW-1] ? -sat[DATA_W-1:0] : sat[DATA_W-1:0];
    endfunction

    // a clear in the same cycle as a sample gives that sample phase 0
    always_comb begin
        acc_base = iphase_clr ? '0 : acc_q;
        acc_d    = ivalid ? acc_base + inc_q : acc_base;
        idx_d    = acc_base[ACC_W-1 -: PHASE_W];
        si_d     = CONJ ? SW'(pic_q) + SW'(pqs_q) : SW'(pic_q) - SW'(pqs_q);
        sq_d     = CONJ ? SW'(pqc_q) - SW'(pis_q) : SW'(pqc_q) + SW'(pis_q);
    end

    dds_mixer_sincos_lut #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W),
        .AMP     (AMP)
    ) u_lut (
        .iclk (iclk),
        .iidx (idx0_q),
        .osin (lut_sin),
        .ocos (lut_cos)
    );

    always_ff @(posedge iclk) begin
        if (ireset) begin
            acc_q  <= '0;
            inc_q  <= '0;
            vld_q  <= '0;
            ovalid <= 1'b0;
            oi     <= '0;
            oq     <= '0;
            ophase <= '0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= iphase_inc_vld ? iphase_inc : inc_q;
            vld_q  <= {vld_q[2:0], ivalid};
            ovalid <= vld_q[3];
            oi     <= vld_q[3] ? round_sat(si_q) : oi;
            oq     <= vld_q[3] ? round_sat(sq_q) : oq;
            ophase <= vld_q[3] ? idx3_q : ophase;
        end
    end

    // datapath moves every cycle; only the valid bits decide what reaches the outputs
    always_ff @(posedge iclk) begin
        i0_q   <= ii;
        q0_q   <= iq;
        idx0_q <= idx_d;
        i1_q   <= i0_q;
        q1_q   <= q0_q;
        idx1_q <= idx0_q;
        pic_q  <= PW'(i1_q) * PW'(lut_cos);
        pqs_q  <= PW'(q1_q) * PW'(lut_sin);
        pqc_q  <= PW'(q1_q) * PW'(lut_cos);
        pis_q  <= PW'(i1_q) * PW'(lut_sin);
        idx2_q <= idx1_q;
        si_q   <= si_d;
        sq_q   <= sq_d;
        idx3_q <= idx2_q;
    end

endmodule

// File: tb/tb_dds_mixer.sv
// tb_dds_mixer: directed and random checks of up- and down-conversion mixers against a math model
module tb_dds_mixer;
    import dds_mixer_pkg::*;

    localparam int     DW   = DEF_DATA_W;
    localparam int     PHW  = DEF_PHASE_W;
    localparam int     AW   = DEF_ACC_W;
    localparam longint MAXV = 32767;

    typedef struct {
        bit     v;
        longint ph, i0, q0, i1, q1;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst, inc_vld, clr, vin;
    logic [AW-1:0]  inc;
    t_iq            ii, iq, oi0, oq0, oi1, oq1;
    logic           ov0, ov1;
    logic [PHW-1:0] ph0, ph1;

    int        checks = 0;
    int        errors = 0;
    bit [31:0] m_acc, m_inc;
    rec_t      hist[$];
    longint    e_i0, e_q0, e_i1, e_q1, e_ph;

    always #5 clk = ~clk;

    dds_mixer #(.CONJ(1'b0)) u_up (
        .iclk(clk), .ireset(rst), .iphase_inc(inc), .iphase_inc_vld(inc_vld),
        .iphase_clr(clr), .ivalid(vin), .ii(ii), .iq(iq),
        .ovalid(ov0), .oi(oi0), .oq(oq0), .ophase(ph0)
    );

    dds_mixer #(.CONJ(1'b1)) u_dn (
        .iclk(clk), .ireset(rst), .iphase_inc(inc), .iphase_inc_vld(inc_vld),
        .iphase_clr(clr), .ivalid(vin), .ii(ii), .iq(iq),
        .ovalid(ov1), .oi(oi1), .oq(oq1), .ophase(ph1)
    );

    function automatic longint clip(input longint x);
        return (x > MAXV) ? MAXV : (x < -MAXV) ? -MAXV : x;
    endfunction

    function automatic longint tab(input longint k);
        return longint'($rtoi($floor(32767.0 * $sin(2.0 * PI * real'(k) / 4096.0) + 0.5)));
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit v);
        chk("ovalid_up", ov0, v);
        chk("ovalid_dn", ov1, v);
        chk("oi_up", oi0, e_i0);
        chk("oq_up", oq0, e_q0);
        chk("oi_dn", oi1, e_i1);
        chk("oq_dn", oq1, e_q1);
        chk("ophase_up", ph0, e_ph);
        chk("ophase_dn", ph1, e_ph);
    endtask

    task automatic do_reset();
        rst = 1'b1; vin = 1'b0; clr = 1'b0; inc_vld = 1'b0; inc = '0; ii = '0; iq = '0;
        @(posedge clk);
        @(negedge clk);
        e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0; e_ph = 0;
        check_outputs(1'b0);
        rst = 1'b0;
        m_acc = 0;
        m_inc = 0;
        hist.delete();
        repeat (4) hist.push_back('{v: 1'b0, default: 0});
    endtask

    // one input cycle: the model predicts this sample, then the sample from four calls ago is compared
    task automatic cyc(input bit v, input longint di, input longint dq, input bit c,
                       input bit lv, input bit [31:0] li);
        rec_t      r;
        bit [31:0] ph;
        longint    cs, sn;
        vin = v; ii = DW'(di); iq = DW'(dq); clr = c; inc_vld = lv; inc = li;
        ph   = c ? 32'd0 : m_acc;
        r.v  = v;
        r.ph = longint'(ph >> (AW - PHW));
        cs   = tab((r.ph + 1024) % 4096);
        sn   = tab(r.ph);
        r.i0 = clip(div_round(di * cs - dq * sn, DW - 1));
        r.q0 = clip(div_round(dq * cs + di * sn, DW - 1));
        r.i1 = clip(div_round(di * cs + dq * sn, DW - 1));
        r.q1 = clip(div_round(dq * cs - di * sn, DW - 1));
        if (v) m_acc = ph + m_inc;
        else if (c) m_acc = 0;
        if (lv) m_inc = li;
        hist.push_back(r);
        @(posedge clk);
        @(negedge clk);
        r = hist.pop_front();
        if (r.v) begin
            e_i0 = r.i0; e_q0 = r.q0; e_i1 = r.i1; e_q1 = r.q1; e_ph = r.ph;
        end
        check_outputs(r.v);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        do_reset();
        // zero increment: plain pass-through at phase 0
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 0);
        repeat (6) cyc(1'b1, 1000, 0, 1'b0, 1'b0, 0);
        idle(5);
        // quarter-turn steps, both directions via the two instances
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 32'h4000_0000);
        repeat (8) cyc(1'b1, 16384, 0, 1'b0, 1'b0, 0);
        idle(5);
        // saturation at 45 degrees, positive and negative
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 32'h2000_0000);
        cyc(1'b1, 0, 0, 1'b1, 1'b0, 0);
        cyc(1'b1, 32767, 32767, 1'b0, 1'b0, 0);
        cyc(1'b1, 0, 0, 1'b1, 1'b0, 0);
        cyc(1'b1, -32767, -32767, 1'b0, 1'b0, 0);
        idle(5);
        // bubbles 1,0,0,1,1
        cyc(1'b1, 1234, -4321, 1'b0, 1'b0, 0);
        idle(2);
        cyc(1'b1, -20000, 15000, 1'b0, 1'b0, 0);
        cyc(1'b1, 30000, 30000, 1'b0, 1'b0, 0);
        idle(6);
        // increment load, clear and sample together; later samples exercise the old then new increment
        cyc(1'b1, 8000, 8000, 1'b1, 1'b1, 32'h1234_5678);
        cyc(1'b1, 8000, -8000, 1'b0, 1'b0, 0);
        cyc(1'b1, -8000, 8000, 1'b0, 1'b0, 0);
        idle(5);
        // randomized traffic
        for (int n = 0; n < 300; n++)
            cyc($urandom_range(0, 3) != 0, longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0, $urandom);
        idle(5);
        // reset with three samples in flight: none may emerge
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 32'h0800_0000);
        repeat (3) cyc(1'b1, 22222, -11111, 1'b0, 1'b0, 0);
        do_reset();
        idle(7);
        cyc(1'b1, 5000, 6000, 1'b0, 1'b0, 0);
        idle(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
